mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width of both ports and the memory.
REQ-002 Parameter: DATA_W, default 32, data width.
REQ-003 Parameter: MAX_WAIT, default 4, consecutive denied cycles before the fetch port is forced to win.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: i_req  in  1  fetch request; held with i_addr until i_gnt.
REQ-007 Port: i_addr  in  ADDR_W  fetch address.
REQ-008 Port: i_gnt  out  1  fetch request accepted this cycle.
REQ-009 Port: i_valid  out  1  fetch response valid.
REQ-010 Port: i_rdata  out  DATA_W  fetched word.
REQ-011 Port: i_err  out  1  fetch response is a misalignment error.
REQ-012 Port: d_req  in  1  data request; held with d_we, d_addr and d_wdata until d_gnt.
REQ-013 Port: d_we  in  1  1 = store, 0 = load.
REQ-014 Port: d_addr  in  ADDR_W  data address.
REQ-015 Port: d_wdata  in  DATA_W  store data.
REQ-016 Port: d_gnt  out  1  data request accepted this cycle.
REQ-017 Port: d_valid  out  1  load data or store acknowledge valid.
REQ-018 Port: d_rdata  out  DATA_W  loaded word (0 on stores).
REQ-019 Port: d_err  out  1  data response is a misalignment error.
REQ-020 Port: mem_raddr  out  ADDR_W  shared memory read address (combinational read).
REQ-021 Port: mem_rdata  in  DATA_W  shared memory read data, same cycle.
REQ-022 Port: mem_waddr  out  ADDR_W  shared memory write address.
REQ-023 Port: mem_wdata  out  DATA_W  shared memory write data.
REQ-024 Port: mem_wen  out  1  shared memory write enable; write commits on clk.

Function
REQ-025 At most one grant per cycle; grant is combinational from req, the port's misalignment check and the wait counter.
REQ-026 Default priority: data over fetch when both request.
REQ-027 Wait counter increments each cycle i_req=1 and i_gnt=0, saturating at MAX_WAIT; it clears on i_gnt or when i_req=0.
REQ-028 When the wait counter equals MAX_WAIT and i_req=1, the fetch port is granted regardless of d_req.
REQ-029 Granted aligned load/fetch: mem_raddr = granted addr in grant cycle N; mem_rdata registered into the port's rdata; valid=1 in cycle N+1 only.
REQ-030 Granted aligned store: mem_waddr/mem_wdata = d_addr/d_wdata and mem_wen=1 in cycle N; d_valid=1 and d_rdata=0 in N+1.
REQ-031 Misaligned request (addr[1:0] != 0): granted normally; no memory access and mem_wen=0; valid=1, err=1, rdata=0 in N+1.
REQ-032 Back-to-back: a new grant is allowed in N+1 while the response for cycle N is presented; sustained throughput is one access per cycle.
REQ-033 When not granting: mem_wen=0; mem_raddr/mem_waddr/mem_wdata = 0.
REQ-034 Grant state machine states: IDLE, GNT_I, GNT_D.
  - Next state is GNT_I or GNT_D on the corresponding grant, otherwise IDLE.
  - The registered state selects which response port pulses valid.

Reset
REQ-035 While rst=1 at a clock edge: state=IDLE, wait counter=0, all valid/err/rdata outputs=0.
REQ-036 Requests presented in the same cycle as rst=1 are not granted (i_gnt=d_gnt=0, mem_wen=0).
REQ-037 A response pending when rst asserts is discarded, never delivered.

Structure
REQ-038 Shared package mem_arb_pkg holds:
  - grant-state enum IDLE/GNT_I/GNT_D;
  - misalignment-mask constant;
  - default MAX_WAIT.
REQ-039 Single sub-module starve_cnt holds the saturating wait counter and its force output; all other logic is in mem_arbiter.

Verification
REQ-040 Fetch only: i_req=1, i_addr=0x10, mem[0x10]=0xDEADBEEF -> i_gnt in the same cycle; i_valid=1, i_rdata=0xDEADBEEF next cycle.
REQ-041 Contention: i_req and d_req both held, d_addr=0x20 -> d_gnt first; after 4 denied fetch cycles, i_gnt=1 on the 5th cycle; counter returns to 0.
REQ-042 Store then load: store 0x12345678 to 0x40, then load 0x40 next cycle -> mem_wen pulses once; d_valid on 2 consecutive cycles; second d_rdata=0x12345678.
REQ-043 Misaligned: d_req, d_we=1, d_addr=0x43 -> mem_wen stays 0; d_valid=1, d_err=1, d_rdata=0 next cycle.
REQ-044 Reset mid-operation: grant load at N, rst=1 at N+1 -> d_valid=0 at N+1 and N+2; no grants while rst=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } gnt_state_e;

  localparam logic [1:0] MISALIGN_MASK    = 2'b11;
  localparam int         DEFAULT_MAX_WAIT = 4;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |(lsb & MISALIGN_MASK);
  endfunction

endpackage

// File: rtl/starve_cnt.sv
// Saturating count of consecutive denied fetch cycles; force_gnt once it reaches MAX_WAIT.
module starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic force_gnt
);

  // One extra code point keeps the width legal even for MAX_WAIT = 0.
  localparam int                CNT_W   = $clog2(MAX_WAIT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!req || gnt) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_gnt = req && (cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one combinational-read memory; one grant per cycle,
// response one cycle later, data has priority unless fetch has starved for MAX_WAIT cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen
);

  gnt_state_e        state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              i_mis, d_mis, force_i;

  assign i_mis = is_misaligned(i_addr[1:0]);
  assign d_mis = is_misaligned(d_addr[1:0]);

  starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .req      (i_req),
    .gnt      (i_gnt),
    .force_gnt(force_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = IDLE;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    rdata_d   = '0;
    err_d     = 1'b0;
    if (!rst) begin
      if (i_req && (force_i || !d_req)) begin
        i_gnt   = 1'b1;
        state_d = GNT_I;
        err_d   = i_mis;
        if (!i_mis) begin
          mem_raddr = i_addr;
          rdata_d   = mem_rdata;
        end
      end else if (d_req) begin
        d_gnt   = 1'b1;
        state_d = GNT_D;
        err_d   = d_mis;
        if (!d_mis) begin
          if (d_we) begin
            mem_waddr = d_addr;
            mem_wdata = d_wdata;
            mem_wen   = 1'b1;
          end else begin
            mem_raddr = d_addr;
            rdata_d   = mem_rdata;
          end
        end
      end
    end
  end

  // Gating with rst drops a response that was already registered when reset arrives.
  assign i_valid = !rst && (state_q == GNT_I);
  assign d_valid = !rst && (state_q == GNT_D);
  assign i_err   = i_valid && err_q;
  assign d_err   = d_valid && err_q;
  assign i_rdata = i_valid ? rdata_q : '0;
  assign d_rdata = d_valid ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences, and random traffic vs. a reference model.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_valid, i_err, d_gnt, d_valid, d_err, mem_wen;
  logic [31:0] i_rdata, d_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;

  logic [31:0] tb_mem    [64];
  logic [31:0] model_mem [64];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int          wait_cnt = 0;
  bit          pend_i = 0, pend_d = 0, pend_err = 0;
  logic [31:0] pend_data = '0;
  bit          m_ig, m_dg;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen)
  );

  assign mem_rdata = tb_mem[mem_raddr[7:2]];
  always @(posedge clk) if (mem_wen) tb_mem[mem_waddr[7:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic model_check();
    bit          e_wen, rv;
    logic [31:0] e_raddr;
    m_ig = 0;
    m_dg = 0;
    if (!rst) begin
      if (i_req && wait_cnt == MAX_WAIT) m_ig = 1;
      else if (d_req)                    m_dg = 1;
      else if (i_req)                    m_ig = 1;
    end
    e_wen   = m_dg && d_we && (d_addr[1:0] == 2'b00);
    e_raddr = (m_ig && i_addr[1:0] == 2'b00) ? i_addr :
              (m_dg && !d_we && d_addr[1:0] == 2'b00) ? d_addr : 32'h0;
    rv = !rst;
    chk("m_i_gnt",     32'(i_gnt),   32'(m_ig));
    chk("m_d_gnt",     32'(d_gnt),   32'(m_dg));
    chk("m_mem_wen",   32'(mem_wen), 32'(e_wen));
    chk("m_mem_raddr", mem_raddr,    e_raddr);
    chk("m_mem_waddr", mem_waddr,    e_wen ? d_addr  : 32'h0);
    chk("m_mem_wdata", mem_wdata,    e_wen ? d_wdata : 32'h0);
    chk("m_i_valid",   32'(i_valid), 32'(rv && pend_i));
    chk("m_i_err",     32'(i_err),   32'(rv && pend_i && pend_err));
    chk("m_i_rdata",   i_rdata,      (rv && pend_i) ? pend_data : 32'h0);
    chk("m_d_valid",   32'(d_valid), 32'(rv && pend_d));
    chk("m_d_err",     32'(d_err),   32'(rv && pend_d && pend_err));
    chk("m_d_rdata",   d_rdata,      (rv && pend_d) ? pend_data : 32'h0);
  endtask

  task automatic model_advance();
    @(posedge clk);
    if (rst) begin
      wait_cnt = 0;
      pend_i   = 0;
      pend_d   = 0;
    end else begin
      if (!i_req || m_ig)         wait_cnt = 0;
      else if (wait_cnt < MAX_WAIT) wait_cnt++;
      pend_i = m_ig;
      pend_d = m_dg;
      if (m_ig) begin
        pend_err  = (i_addr[1:0] != 2'b00);
        pend_data = pend_err ? 32'h0 : model_mem[i_addr[7:2]];
      end else if (m_dg) begin
        pend_err  = (d_addr[1:0] != 2'b00);
        pend_data = (pend_err || d_we) ? 32'h0 : model_mem[d_addr[7:2]];
        if (!pend_err && d_we) model_mem[d_addr[7:2]] = d_wdata;
      end
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dwe, input logic [31:0] da,
                       input logic [31:0] dwd);
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  typedef struct {
    logic        rst, ir;
    logic [31:0] ia;
    logic        dr, dwe;
    logic [31:0] da, dwd;
    logic        e_ig, e_dg, e_wen, e_iv;
    logic [31:0] e_ird;
    logic        e_ie, e_dv;
    logic [31:0] e_drd;
    logic        e_de;
  } vec_t;

  vec_t tbl [10];

  initial begin
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]    = 32'h1000_0000 + 32'(i);
      model_mem[i] = 32'h1000_0000 + 32'(i);
    end
    tb_mem[4]    = 32'hDEADBEEF;
    model_mem[4] = 32'hDEADBEEF;

    //          rst ir ia     dr dwe da     dwd            ig dg wen iv ird           ie dv drd           de
    tbl[0] = '{1, 1, 32'h10, 1, 1, 32'h40, 32'hAAAA5555, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0};
    tbl[1] = '{0, 1, 32'h10, 0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0};
    tbl[2] = '{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0};
    tbl[3] = '{0, 0, 32'h0,  1, 1, 32'h40, 32'h12345678, 0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0};
    tbl[4] = '{0, 0, 32'h0,  1, 0, 32'h40, 32'h0,        0, 1, 0, 0, 32'h0,        0, 1, 32'h0,        0};
    tbl[5] = '{0, 0, 32'h0,  1, 1, 32'h43, 32'hFFFFFFFF, 0, 1, 0, 0, 32'h0,        0, 1, 32'h12345678, 0};
    tbl[6] = '{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 32'h0,        1};
    tbl[7] = '{0, 1, 32'h12, 0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0};
    tbl[8] = '{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 32'h0,        1, 0, 32'h0,        0};
    tbl[9] = '{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0};

    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].rst, tbl[k].ir, tbl[k].ia, tbl[k].dr, tbl[k].dwe, tbl[k].da, tbl[k].dwd);
      @(negedge clk);
      chk($sformatf("t%0d_i_gnt", k),   32'(i_gnt),   32'(tbl[k].e_ig));
      chk($sformatf("t%0d_d_gnt", k),   32'(d_gnt),   32'(tbl[k].e_dg));
      chk($sformatf("t%0d_mem_wen", k), 32'(mem_wen), 32'(tbl[k].e_wen));
      chk($sformatf("t%0d_i_valid", k), 32'(i_valid), 32'(tbl[k].e_iv));
      chk($sformatf("t%0d_i_rdata", k), i_rdata,      tbl[k].e_ird);
      chk($sformatf("t%0d_i_err", k),   32'(i_err),   32'(tbl[k].e_ie));
      chk($sformatf("t%0d_d_valid", k), 32'(d_valid), 32'(tbl[k].e_dv));
      chk($sformatf("t%0d_d_rdata", k), d_rdata,      tbl[k].e_drd);
      chk($sformatf("t%0d_d_err", k),   32'(d_err),   32'(tbl[k].e_de));
      model_check();
      model_advance();
    end

    // Contention: data wins four times, then the starved fetch is forced, then data again.
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 32'h10, 1, 0, 32'h20, 32'h0);
      @(negedge clk);
      chk($sformatf("cont%0d_d_gnt", k), 32'(d_gnt), (k == 4) ? 32'h0 : 32'h1);
      chk($sformatf("cont%0d_i_gnt", k), 32'(i_gnt), (k == 4) ? 32'h1 : 32'h0);
      model_check();
      model_advance();
    end

    // Reset arriving while a load response is pending.
    drive(0, 0, 32'h0, 1, 0, 32'h40, 32'h0);
    @(negedge clk);
    chk("rst_seq_load_gnt", 32'(d_gnt), 32'h1);
    model_check();
    model_advance();
    drive(1, 1, 32'h10, 1, 1, 32'h40, 32'h5);
    @(negedge clk);
    chk("rst_seq_d_valid_n1", 32'(d_valid), 32'h0);
    chk("rst_seq_no_dgnt",    32'(d_gnt),   32'h0);
    chk("rst_seq_no_ignt",    32'(i_gnt),   32'h0);
    chk("rst_seq_no_wen",     32'(mem_wen), 32'h0);
    model_check();
    model_advance();
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rst_seq_d_valid_n2", 32'(d_valid), 32'h0);
    model_check();
    model_advance();

    // Random traffic; an ungranted request is held unchanged.
    for (int c = 0; c < 400; c++) begin
      if (!(i_req && !m_ig)) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = rand_addr();
      end
      if (!(d_req && !m_dg)) begin
        d_req   = ($urandom_range(0, 1) != 0);
        d_we    = ($urandom_range(0, 1) != 0);
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end
      rst = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      model_check();
      model_advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
